// File: rtl/l2_norm_sqrt.sv
// Iterative restoring integer square root: floor(sqrt(x_in)) and remainder,
// one result bit per clock, valid/ready handshakes on both sides.
module l2_norm_sqrt #(
  parameter int IN_W  = 20,
  parameter int OUT_W = IN_W / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  x_in,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [OUT_W-1:0] root,
  output logic [OUT_W:0]   rem,
  output logic             valid_out,
  input  logic             ready_out
);

  localparam int ITER_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int STEP_W = OUT_W + OUT_W + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_nxt;
  logic [IN_W-1:0]     op;
  logic [OUT_W:0]      rem_acc, rem_nxt;
  logic [OUT_W-1:0]    root_acc, root_nxt;
  logic [ITER_W-1:0]   iter;
  logic                accept;
  logic [STEP_W-1:0]   step;

  // One restoring step: trial-subtract (4*root+1) from the remainder extended
  // by the next operand bit pair. Partial remainder never exceeds 2*root, so
  // OUT_W+3 bits hold the signed difference without wrap.
  function automatic logic [STEP_W-1:0] sqrt_step(
    input logic [OUT_W:0]   r_acc,
    input logic [OUT_W-1:0] q_acc,
    input logic [1:0]       pair
  );
    logic [OUT_W+2:0]        shifted;
    logic signed [OUT_W+2:0] t;
    logic [OUT_W:0]          q_ext;
    logic [OUT_W:0]          r_new;
    shifted = {r_acc, pair};
    t       = $signed(shifted - {1'b0, q_acc, 2'b01});
    if (t >= 0) begin
      q_ext = {q_acc, 1'b1};
      r_new = t[OUT_W:0];
    end else begin
      q_ext = {q_acc, 1'b0};
      r_new = shifted[OUT_W:0];
    end
    return {q_ext[OUT_W-1:0], r_new};
  endfunction

  assign step     = sqrt_step(rem_acc, root_acc, op[IN_W-1:IN_W-2]);
  assign root_nxt = step[STEP_W-1:OUT_W+1];
  assign rem_nxt  = step[OUT_W:0];

  assign ready_in  = (state == IDLE) | ((state == DONE) & ready_out);
  assign valid_out = (state == DONE);
  assign accept    = valid_in & ready_in;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (iter == '0) state_nxt = DONE;
      DONE: if (ready_out) state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op       <= '0;
      rem_acc  <= '0;
      root_acc <= '0;
      iter     <= '0;
      root     <= '0;
      rem      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op       <= x_in;
        rem_acc  <= '0;
        root_acc <= '0;
        iter     <= ITER_W'(OUT_W - 1);
      end else if (state == CALC) begin
        op       <= op << 2;
        rem_acc  <= rem_nxt;
        root_acc <= root_nxt;
        iter     <= iter - 1'b1;
        if (iter == '0) begin
          root <= root_nxt;
          rem  <= rem_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_norm_sqrt.sv
// Directed + randomized bench for l2_norm_sqrt with an in-order result scoreboard.
module tb_l2_norm_sqrt;

  localparam int IN_W  = 20;
  localparam int OUT_W = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic [IN_W-1:0]  x_in;
  logic             valid_in;
  logic             ready_in;
  logic [OUT_W-1:0] root;
  logic [OUT_W:0]   rem;
  logic             valid_out;
  logic             ready_out;

  int tests = 0;
  int fails = 0;
  int n_acc = 0;
  int n_out = 0;
  int sb[$];

  l2_norm_sqrt #(.IN_W(IN_W)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .valid_in(valid_in),
    .ready_in(ready_in), .root(root), .rem(rem), .valid_out(valid_out),
    .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  function automatic longint isqrt(longint x);
    longint r = 0;
    for (int b = OUT_W - 1; b >= 0; b--) begin
      longint c = r | (longint'(1) << b);
      if (c * c <= x) r = c;
    end
    return r;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on result handoff.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
    end else begin
      if (valid_out && ready_out) begin
        tests++;
        assert (sb.size() != 0) else begin
          fails++;
          $error("FAIL sb_extra_result: observed root %0d rem %0d, expected no result", root, rem);
        end
        if (sb.size() != 0) begin
          longint x, r;
          x = sb.pop_front();
          r = isqrt(x);
          check("sb_root", root, r);
          check("sb_rem", rem, x - r * r);
          check("sb_inv_sum", longint'(root) * longint'(root) + longint'(rem), x);
          check("sb_rem_le_2root", (longint'(rem) <= 2 * longint'(root)), 1);
        end
        n_out++;
      end
      if (valid_in && ready_in) begin
        sb.push_back(int'(x_in));
        n_acc++;
      end
    end
  end

  task automatic send(input logic [IN_W-1:0] x);
    int w = 0;
    while (!ready_in && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("send_ready", ready_in, 1);
    x_in = x;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_out && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic directed(input logic [IN_W-1:0] x, input int er, input int erem);
    int lat;
    send(x);
    check("ready_in_drop", ready_in, 0);
    wait_valid(lat);
    check("latency", lat, 10);
    check("dir_root", root, er);
    check("dir_rem", rem, erem);
    @(posedge clk); #1;
    check("valid_one_cycle", valid_out, 0);
    check("ready_in_back", ready_in, 1);
  endtask

  function automatic logic [IN_W-1:0] rnd_operand();
    int r;
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: begin r = $urandom_range(0, 1023); return IN_W'(r * r); end
      3: begin r = $urandom_range(1, 1023); return IN_W'(r * r - 1); end
      default: return IN_W'($urandom);
    endcase
  endfunction

  initial begin
    int lat, lat2, seen, issued, prev, cyc, a0, o0;
    reset = 1'b0; x_in = '0; valid_in = 1'b0; ready_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_root", root, 0);
    check("rst_rem", rem, 0);
    check("rst_valid", valid_out, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_in", ready_in, 1);

    ready_out = 1'b1;
    directed(20'd144, 12, 0);
    directed(20'd200, 14, 4);
    directed(20'd0, 0, 0);
    directed(20'd1048575, 1023, 2046);

    // Stall downstream; operand changes during CALC must not matter.
    ready_out = 1'b0;
    send(20'd260100);
    lat = 0;
    while (!valid_out && lat < 40) begin
      x_in = IN_W'($urandom);
      @(posedge clk); #1; lat++;
    end
    check("hold_latency", lat, 10);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", valid_out, 1);
      check("hold_root", root, 510);
      check("hold_rem", rem, 0);
      @(posedge clk); #1;
    end
    ready_out = 1'b1;
    @(posedge clk); #1;
    check("hold_release", valid_out, 0);

    // Back-to-back: second accept on the first result's handoff edge.
    send(20'd65025);
    x_in = 20'd65026;
    valid_in = 1'b1;
    wait_valid(lat);
    check("b2b_lat1", lat, 10);
    check("b2b_root1", root, 255);
    check("b2b_rem1", rem, 0);
    check("b2b_ready_done", ready_in, 1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("b2b_handoff_valid", valid_out, 0);
    check("b2b_busy", ready_in, 0);
    wait_valid(lat2);
    check("b2b_spacing", lat2 + 1, 11);
    check("b2b_root2", root, 255);
    check("b2b_rem2", rem, 1);
    @(posedge clk); #1;

    // Reset in the middle of CALC aborts the operation.
    send(20'd999);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_root", root, 0);
    check("abort_rem", rem, 0);
    check("abort_valid", valid_out, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (valid_out) seen++;
    end
    check("abort_no_pulse", seen, 0);
    directed(20'd999, 31, 38);

    // Randomized operands and downstream backpressure.
    a0 = n_acc; o0 = n_out;
    issued = 0; prev = n_acc; cyc = 0;
    x_in = rnd_operand();
    valid_in = 1'b1;
    while (issued < 2000 && cyc < 80000) begin
      ready_out = 1'($urandom_range(0, 1));
      @(posedge clk); #1; cyc++;
      if (n_acc != prev) begin
        prev = n_acc;
        issued++;
        valid_in = ($urandom_range(0, 3) != 0);
        x_in = rnd_operand();
      end else if (!valid_in) begin
        valid_in = 1'b1;
      end
    end
    valid_in = 1'b0;
    check("rand_issued", issued, 2000);
    ready_out = 1'b1;
    cyc = 0;
    while ((sb.size() != 0 || valid_out) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("rand_drained", sb.size(), 0);
    check("rand_count", n_out - o0, n_acc - a0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
